// File: rtl/ontest_fpu_seq.sv
// On-board FPU self-test sequencer: LFSR-driven operand campaign with a MISR result signature.
// Optional feature macro: ONTEST_SPECIAL_EN forces special exponents into every 8th operand A.
module ontest_fpu_seq #(
    parameter int unsigned NUM_OPS     = 1,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [31:0] SEED        = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    input  logic [31:0] res_in,
    input  logic        res_valid,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [31:0] signature,
    output logic [31:0] vec_count,
    output logic [31:0] result_debug
);
    localparam logic [31:0] NV        = 32'(NUM_VECTORS);
    localparam logic [31:0] TO_LAST   = 32'(LATENCY + 3);
    localparam logic [31:0] LFSR_POLY = 32'h00400007;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] issue_q, issue_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dbg_q, dbg_d;
    logic        op_valid_q, op_valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        launch, issue, accept;
    logic [31:0] src, src_next, idx;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? LFSR_POLY : 32'h0);
    endfunction

`ifdef ONTEST_SPECIAL_EN
    function automatic logic [7:0] special_exp(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'h00;
            2'd1:    return 8'hFF;
            2'd2:    return 8'h9E;
            default: return 8'h7F;
        endcase
    endfunction
`endif

    // A launch issues vector 0 straight from SEED on the start edge, so RUN
    // always shows a valid operand on its first cycle.
    always_comb begin
        launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
        issue    = launch || ((state_q == S_RUN) && (issue_q < NV));
        src      = launch ? SEED : lfsr_q;
        idx      = launch ? 32'h0 : issue_q;
        src_next = lfsr_step(src);
        accept   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && res_valid && (cnt_q < NV);
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        issue_d    = issue_q;
        timer_d    = timer_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        dbg_d      = dbg_q;
        err_d      = err_q;

        if (accept) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ res_in;
            cnt_d = cnt_q + 32'd1;
            dbg_d = res_in;
        end

        if (issue) begin
            op_a_d = src;
`ifdef ONTEST_SPECIAL_EN
            if (idx[2:0] == 3'b111) op_a_d[30:23] = special_exp(idx[4:3]);
`endif
            op_b_d     = (NUM_OPS == 2) ? src_next : 32'h0;
            lfsr_d     = (NUM_OPS == 2) ? lfsr_step(src_next) : src_next;
            issue_d    = idx + 32'd1;
            op_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    sig_d   = '1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (!issue) begin
                    state_d    = S_DRAIN;
                    op_valid_d = 1'b0;
                    timer_d    = '0;
                end
            end
            S_DRAIN: begin
                // A result landing on the expiry cycle still counts and rearms the timer.
                if (cnt_d == NV) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            issue_q    <= '0;
            timer_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            sig_q      <= '1;
            cnt_q      <= '0;
            dbg_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            issue_q    <= issue_d;
            timer_q    <= timer_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            sig_q      <= sig_d;
            cnt_q      <= cnt_d;
            dbg_q      <= dbg_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_valid     = op_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign signature    = sig_q;
    assign vec_count    = cnt_q;
    assign result_debug = dbg_q;

endmodule
